// File: rtl/frame_seq_ctrl.sv
// Per-frame sequencer for the crop-filter -> norm_reader chain: launches both blocks, waits for
// both completions, audits the crop-filter output beat count and supplies norm_denominator.
module frame_seq_ctrl #(
    parameter int OUT_ROWS       = 10,
    parameter int OUT_COLS       = 10,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 enable,
    input  logic                 frame_req,
    input  logic                 norm_mode,
    input  logic [7:0]           cfg_norm_den,
    input  logic                 err_clr,
    output logic                 busy,
    output logic                 frame_done,
    output logic [CNT_WIDTH-1:0] frame_count,
    output logic                 timeout_err,
    output logic                 count_err,
    output logic                 cf_ap_start,
    input  logic                 cf_ap_ready,
    input  logic                 cf_ap_done,
    output logic                 nr_ap_start,
    input  logic                 nr_ap_ready,
    input  logic                 nr_ap_done,
    input  logic                 mon_tvalid,
    input  logic                 mon_tready,
    input  logic [7:0]           mon_tdata,
    output logic [7:0]           norm_denominator
);
    localparam int BEATS  = OUT_ROWS * OUT_COLS;
    localparam int BEAT_W = $clog2(BEATS + 2);
    localparam int TMO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [BEAT_W-1:0] BEAT_N   = BEAT_W'(BEATS);
    localparam logic [BEAT_W-1:0] BEAT_SAT = BEAT_W'(BEATS + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

    state_t                state_q;
    logic                  pending_q;
    logic                  cf_start_q, nr_start_q;
    logic                  cf_acc_q, nr_acc_q;
    logic                  cf_done_q, nr_done_q;
    logic [BEAT_W-1:0]     beat_cnt_q;
    logic [7:0]            max_q, max_prev_q;
    logic [TMO_W-1:0]      tmo_cnt_q;
    logic                  frame_done_q;
    logic [CNT_WIDTH-1:0]  frame_count_q;
    logic                  timeout_err_q, count_err_q;
    logic [7:0]            norm_den_q;

    logic                  active, beat;
    logic                  cf_acc_now, nr_acc_now;
    logic                  cf_acc_d, nr_acc_d;
    logic                  cf_done_d, nr_done_d;
    logic [BEAT_W-1:0]     beat_cnt_d;
    logic [7:0]            max_d;
    logic                  tmo_hit, fin, go_start;

    // A zero denominator would make norm_reader divide by zero, so it is lifted to 1.
    function automatic logic [7:0] den_fix(input logic [7:0] v);
        return (v == 8'd0) ? 8'd1 : v;
    endfunction

    always_comb begin
        active     = (state_q == START) || (state_q == RUN);
        beat       = mon_tvalid && mon_tready;
        cf_acc_now = (state_q == START) && cf_start_q && cf_ap_ready;
        nr_acc_now = (state_q == START) && nr_start_q && nr_ap_ready;
        cf_acc_d   = cf_acc_q || cf_acc_now;
        nr_acc_d   = nr_acc_q || nr_acc_now;
        cf_done_d  = cf_done_q || (active && cf_acc_d && cf_ap_done);
        nr_done_d  = nr_done_q || (active && nr_acc_d && nr_ap_done);
        beat_cnt_d = beat_cnt_q;
        if (active && beat && (beat_cnt_q != BEAT_SAT))
            beat_cnt_d = beat_cnt_q + 1'b1;
        max_d = max_q;
        if (active && beat && (mon_tdata > max_q))
            max_d = mon_tdata;
        tmo_hit  = active && (tmo_cnt_q == TMO_LAST);
        fin      = (state_q == RUN) && cf_done_d && nr_done_d && !tmo_hit;
        go_start = enable && (((state_q == IDLE) && (frame_req || pending_q)) ||
                              ((state_q == DONE) && pending_q));
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state_q       <= IDLE;
            pending_q     <= 1'b0;
            cf_start_q    <= 1'b0;
            nr_start_q    <= 1'b0;
            cf_acc_q      <= 1'b0;
            nr_acc_q      <= 1'b0;
            cf_done_q     <= 1'b0;
            nr_done_q     <= 1'b0;
            beat_cnt_q    <= '0;
            max_q         <= 8'd0;
            max_prev_q    <= 8'd0;
            tmo_cnt_q     <= '0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            timeout_err_q <= 1'b0;
            count_err_q   <= 1'b0;
            norm_den_q    <= 8'd1;
        end else begin
            frame_done_q <= 1'b0;
            // Clears are written first so a same-cycle set below takes precedence.
            if (err_clr) begin
                timeout_err_q <= 1'b0;
                count_err_q   <= 1'b0;
            end
            if (frame_req && (state_q != IDLE))
                pending_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    norm_den_q <= den_fix(norm_mode ? max_prev_q : cfg_norm_den);
                end
                START, RUN: begin
                    beat_cnt_q <= beat_cnt_d;
                    max_q      <= max_d;
                    tmo_cnt_q  <= tmo_cnt_q + 1'b1;
                    cf_acc_q   <= cf_acc_d;
                    nr_acc_q   <= nr_acc_d;
                    cf_done_q  <= cf_done_d;
                    nr_done_q  <= nr_done_d;
                    if (cf_acc_now)
                        cf_start_q <= 1'b0;
                    if (nr_acc_now)
                        nr_start_q <= 1'b0;
                    if (tmo_hit) begin
                        timeout_err_q <= 1'b1;
                        cf_start_q    <= 1'b0;
                        nr_start_q    <= 1'b0;
                        pending_q     <= 1'b0;
                        state_q       <= IDLE;
                    end else if ((state_q == START) && cf_acc_d && nr_acc_d) begin
                        state_q <= RUN;
                    end else if (fin) begin
                        state_q       <= DONE;
                        frame_done_q  <= 1'b1;
                        frame_count_q <= frame_count_q + 1'b1;
                        if (beat_cnt_d != BEAT_N)
                            count_err_q <= 1'b1;
                        max_prev_q    <= max_d;
                        norm_den_q    <= den_fix(norm_mode ? max_d : cfg_norm_den);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            // Frame launch overrides the IDLE/DONE bookkeeping above.
            if (go_start) begin
                state_q    <= START;
                pending_q  <= 1'b0;
                cf_start_q <= 1'b1;
                nr_start_q <= 1'b1;
                cf_acc_q   <= 1'b0;
                nr_acc_q   <= 1'b0;
                cf_done_q  <= 1'b0;
                nr_done_q  <= 1'b0;
                beat_cnt_q <= '0;
                max_q      <= 8'd0;
                tmo_cnt_q  <= '0;
            end
        end
    end

    assign busy             = (state_q != IDLE);
    assign frame_done       = frame_done_q;
    assign frame_count      = frame_count_q;
    assign timeout_err      = timeout_err_q;
    assign count_err        = count_err_q;
    assign cf_ap_start      = cf_start_q;
    assign nr_ap_start      = nr_start_q;
    assign norm_denominator = norm_den_q;

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Directed bench for frame_seq_ctrl: frame results are queued when a frame is driven and
// compared when frame_done pulses; a second instance with a short timeout covers the timeout path.
module tb_frame_seq_ctrl;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic srst, enable, frame_req, norm_mode, err_clr;
    logic [7:0] cfg_norm_den, mon_tdata;
    logic cf_ap_ready, cf_ap_done, nr_ap_ready, nr_ap_done, mon_tvalid, mon_tready;

    logic busy, frame_done, timeout_err, count_err, cf_ap_start, nr_ap_start;
    logic [CW-1:0] frame_count;
    logic [7:0] norm_denominator;

    logic t_busy, t_frame_done, t_timeout_err, t_count_err, t_cf_ap_start, t_nr_ap_start;
    logic [CW-1:0] t_frame_count;
    logic [7:0] t_norm_denominator;

    always #5 clk = ~clk;

    frame_seq_ctrl #(.OUT_ROWS(10), .OUT_COLS(10), .TIMEOUT_CYCLES(65536), .CNT_WIDTH(CW)) u_dut (
        .clk(clk), .srst(srst), .enable(enable), .frame_req(frame_req), .norm_mode(norm_mode),
        .cfg_norm_den(cfg_norm_den), .err_clr(err_clr), .busy(busy), .frame_done(frame_done),
        .frame_count(frame_count), .timeout_err(timeout_err), .count_err(count_err),
        .cf_ap_start(cf_ap_start), .cf_ap_ready(cf_ap_ready), .cf_ap_done(cf_ap_done),
        .nr_ap_start(nr_ap_start), .nr_ap_ready(nr_ap_ready), .nr_ap_done(nr_ap_done),
        .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tdata(mon_tdata),
        .norm_denominator(norm_denominator)
    );

    frame_seq_ctrl #(.OUT_ROWS(10), .OUT_COLS(10), .TIMEOUT_CYCLES(64), .CNT_WIDTH(CW)) u_tmo (
        .clk(clk), .srst(srst), .enable(enable), .frame_req(frame_req), .norm_mode(norm_mode),
        .cfg_norm_den(cfg_norm_den), .err_clr(err_clr), .busy(t_busy), .frame_done(t_frame_done),
        .frame_count(t_frame_count), .timeout_err(t_timeout_err), .count_err(t_count_err),
        .cf_ap_start(t_cf_ap_start), .cf_ap_ready(cf_ap_ready), .cf_ap_done(cf_ap_done),
        .nr_ap_start(t_nr_ap_start), .nr_ap_ready(nr_ap_ready), .nr_ap_done(nr_ap_done),
        .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tdata(mon_tdata),
        .norm_denominator(t_norm_denominator)
    );

    typedef struct packed {
        logic [CW-1:0] cnt;
        logic          cerr;
        logic [7:0]    den;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            n_total = 0;
    int            n_fail = 0;
    int            done_pulses = 0;
    int            frames_pushed = 0;
    logic [CW-1:0] m_count;
    logic          m_cerr;
    logic [7:0]    m_maxprev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] fix_den(input logic [7:0] v);
        return (v == 8'd0) ? 8'd1 : v;
    endfunction

    function automatic logic [7:0] pix_of(input int b, input logic [7:0] maxpix);
        if (maxpix == 8'd0) return 8'd0;
        if (b == 37) return maxpix;
        return 8'((b * 7) % int'(maxpix));
    endfunction

    task automatic do_reset();
        srst = 1'b1;
        step();
        step();
        srst = 1'b0;
        m_count   = '0;
        m_cerr    = 1'b0;
        m_maxprev = 8'd0;
    endtask

    // Drives one frame; returns with the DUT in DONE.
    task automatic do_frame(input bit send_req, input int nbeats, input logic [7:0] maxpix,
                            input bit extra_reqs, input bit split_done);
        exp_t e;
        int   b;
        int   cyc;
        m_count   = m_count + 1'b1;
        m_cerr    = m_cerr | (nbeats != 100);
        m_maxprev = maxpix;
        e.cnt  = m_count;
        e.cerr = m_cerr;
        e.den  = fix_den(norm_mode ? m_maxprev : cfg_norm_den);
        sb.push_back(e);
        frames_pushed++;
        if (send_req) begin
            frame_req = 1'b1;
            step();
            frame_req = 1'b0;
        end else begin
            step();
        end
        b = 0;
        cyc = 0;
        while (b < nbeats || cyc < 3) begin
            if (cyc == 0) begin
                chk("start_cf_rise", 32'(cf_ap_start), 32'd1);
                chk("start_nr_rise", 32'(nr_ap_start), 32'd1);
                chk("start_busy", 32'(busy), 32'd1);
            end
            if (cyc == 1) begin
                chk("cf_start_drop", 32'(cf_ap_start), 32'd0);
                chk("nr_start_hold", 32'(nr_ap_start), 32'd1);
            end
            if (cyc == 3) chk("nr_start_drop", 32'(nr_ap_start), 32'd0);
            cf_ap_ready = (cyc == 0);
            nr_ap_ready = (cyc == 2);
            frame_req   = extra_reqs && (cyc == 10 || cyc == 12 || cyc == 14);
            if (cyc % 5 == 4) begin
                mon_tvalid = 1'b1; mon_tready = 1'b0; mon_tdata = 8'hFF;
            end else if (b < nbeats) begin
                mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tdata = pix_of(b, maxpix);
                b++;
            end else begin
                mon_tvalid = 1'b0; mon_tready = 1'b1; mon_tdata = 8'hFF;
            end
            step();
            cyc++;
        end
        cf_ap_ready = 1'b0; nr_ap_ready = 1'b0; frame_req = 1'b0;
        mon_tvalid = 1'b0; mon_tdata = 8'h00;
        if (split_done) begin
            cf_ap_done = 1'b1;
            step();
            cf_ap_done = 1'b0;
            chk("split_wait_busy", 32'(busy), 32'd1);
            chk("split_wait_done", 32'(frame_done), 32'd0);
            nr_ap_done = 1'b1;
            step();
            nr_ap_done = 1'b0;
        end else begin
            cf_ap_done = 1'b1; nr_ap_done = 1'b1;
            step();
            cf_ap_done = 1'b0; nr_ap_done = 1'b0;
        end
        chk("frame_done_pulse", 32'(frame_done), 32'd1);
    endtask

    always @(negedge clk) begin
        if (srst === 1'b0 && frame_done === 1'b1) begin
            done_pulses++;
            if (sb.size() == 0) begin
                chk("spurious_frame_done", 32'(frame_done), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_frame_count", 32'(frame_count), 32'(mon_e.cnt));
                chk("sb_count_err", 32'(count_err), 32'(mon_e.cerr));
                chk("sb_norm_den", 32'(norm_denominator), 32'(mon_e.den));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish within bound");
        $fatal(1, "watchdog expired");
    end

    initial begin
        srst = 1'b1; enable = 1'b1; frame_req = 1'b0; norm_mode = 1'b0; cfg_norm_den = 8'h40;
        err_clr = 1'b0; cf_ap_ready = 1'b0; cf_ap_done = 1'b0; nr_ap_ready = 1'b0;
        nr_ap_done = 1'b0; mon_tvalid = 1'b0; mon_tready = 1'b1; mon_tdata = 8'h00;
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        chk("rst_count_err", 32'(count_err), 32'd0);
        chk("rst_cf_start", 32'(cf_ap_start), 32'd0);
        chk("rst_nr_start", 32'(nr_ap_start), 32'd0);
        chk("rst_norm_den", 32'(norm_denominator), 32'd1);
        srst = 1'b0;
        m_count = '0; m_cerr = 1'b0; m_maxprev = 8'd0;

        // Basic frame, static denominator.
        do_frame(1'b1, 100, 8'h50, 1'b0, 1'b0);
        step();
        chk("t1_idle_busy", 32'(busy), 32'd0);
        chk("t1_frame_count", 32'(frame_count), 32'd1);
        chk("t1_count_err", 32'(count_err), 32'd0);

        // Denominator from previous frame maximum, including an all-zero frame.
        norm_mode = 1'b1;
        step();
        chk("t2_idle_den_prev_max", 32'(norm_denominator), 32'h50);
        do_frame(1'b1, 100, 8'hC8, 1'b0, 1'b1);
        step();
        chk("t2_den_c8_held", 32'(norm_denominator), 32'hC8);
        do_frame(1'b1, 100, 8'h00, 1'b0, 1'b0);
        step();
        chk("t2_den_zero_forced", 32'(norm_denominator), 32'h01);

        // Short frame flags count_err; err_clr clears it; enable=0 blocks requests.
        norm_mode = 1'b0;
        do_frame(1'b1, 99, 8'h30, 1'b0, 1'b0);
        step();
        chk("t4_count_err_sticky", 32'(count_err), 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        m_cerr = 1'b0;
        chk("t4_count_err_clr", 32'(count_err), 32'd0);
        enable = 1'b0;
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
        chk("t4_disabled_busy", 32'(busy), 32'd0);
        step();
        chk("t4_disabled_busy2", 32'(busy), 32'd0);
        enable = 1'b1;

        // Several requests during RUN give exactly one back-to-back frame.
        do_reset();
        do_frame(1'b1, 100, 8'h60, 1'b1, 1'b0);
        do_frame(1'b0, 100, 8'h70, 1'b0, 1'b0);
        step();
        chk("t5_no_third_frame", 32'(busy), 32'd0);
        chk("t5_frame_count", 32'(frame_count), 32'd2);
        step();
        chk("t5_still_idle", 32'(busy), 32'd0);

        // Asynchronous reset while starts are held high.
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
        step();
        step();
        chk("t6_pre_cf_start", 32'(cf_ap_start), 32'd1);
        chk("t6_pre_den", 32'(norm_denominator), 32'h40);
        #2;
        srst = 1'b1;
        #1;
        chk("t6_async_cf_start", 32'(cf_ap_start), 32'd0);
        chk("t6_async_nr_start", 32'(nr_ap_start), 32'd0);
        chk("t6_async_busy", 32'(busy), 32'd0);
        chk("t6_async_den", 32'(norm_denominator), 32'd1);
        chk("t6_async_count", 32'(frame_count), 32'd0);
        step();
        srst = 1'b0;
        m_count = '0; m_cerr = 1'b0; m_maxprev = 8'd0;

        // Timeout on the short-timeout instance: nr_ap_done never arrives.
        do_reset();
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
        for (int c = 0; c < 64; c++) begin
            if (c == 63) begin
                chk("t3_busy_before", 32'(t_busy), 32'd1);
                chk("t3_tmo_before", 32'(t_timeout_err), 32'd0);
            end
            cf_ap_ready = (c == 0);
            nr_ap_ready = (c == 2);
            cf_ap_done  = (c == 5);
            step();
        end
        cf_ap_ready = 1'b0; nr_ap_ready = 1'b0; cf_ap_done = 1'b0;
        chk("t3_timeout_err", 32'(t_timeout_err), 32'd1);
        chk("t3_busy_after", 32'(t_busy), 32'd0);
        chk("t3_cf_start", 32'(t_cf_ap_start), 32'd0);
        chk("t3_nr_start", 32'(t_nr_ap_start), 32'd0);
        chk("t3_frame_count", 32'(t_frame_count), 32'd0);
        chk("t3_no_done", 32'(t_frame_done), 32'd0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("t3_err_clr", 32'(t_timeout_err), 32'd0);

        step();
        chk("sb_drain", 32'(sb.size()), 32'd0);
        chk("done_pulses", 32'(done_pulses), 32'(frames_pushed));
        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end
endmodule
